// File: rtl/mean_pkg.sv
// Shared constants and width helpers for the pipelined mean tree.
package mean_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    // Width of a partial sum after k pairwise-add levels.
    function automatic int stage_w(input int wid, input int k);
        return wid + k;
    endfunction

    // Half of the divisor, added before the final shift for round-half-up.
    function automatic int round_ofs(input int n_log2);
        return (n_log2 > 0) ? (1 << (n_log2 - 1)) : 0;
    endfunction

endpackage

// File: rtl/mean_add_stage.sv
// One level of the adder tree: registered pairwise sums with a travelling valid bit.
module mean_add_stage
    import mean_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int NUM_IN = 8,
    parameter int SIGNED = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic [NUM_IN*IN_W-1:0]              in_data,
    input  logic                                in_valid,
    output logic [(NUM_IN/2)*(IN_W+1)-1:0]      out_data,
    output logic                                out_valid
);

    localparam int NUM_OUT = NUM_IN / 2;
    localparam int OUT_W   = stage_w(IN_W, 1);

    logic [NUM_OUT*OUT_W-1:0] sum_d, sum_q;
    logic                     vld_d, vld_q;

    function automatic logic [OUT_W-1:0] ext(input logic [IN_W-1:0] x);
        return (SIGNED != 0) ? {x[IN_W-1], x} : {1'b0, x};
    endfunction

    always_comb begin
        sum_d = sum_q;
        vld_d = vld_q;
        if (en) begin
            vld_d = in_valid;
            for (int j = 0; j < NUM_OUT; j++) begin
                sum_d[j*OUT_W +: OUT_W] = ext(in_data[(2*j)*IN_W +: IN_W])
                                        + ext(in_data[(2*j+1)*IN_W +: IN_W]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            vld_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            vld_q <= vld_d;
        end
    end

    assign out_data  = sum_q;
    assign out_valid = vld_q;

endmodule

// File: rtl/mean_tree_avg.sv
// Pipelined mean of 2^N_LOG2 samples: adder tree, then a rounding/shift output stage.
module mean_tree_avg
    import mean_pkg::*;
#(
    parameter int WID    = 16,
    parameter int N_LOG2 = 3,
    parameter int SIGNED = 0,
    parameter int ROUND  = ROUND_TRUNC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WID*(1<<N_LOG2)-1:0]    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WID-1:0]                out_mean,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int N  = 1 << N_LOG2;
    localparam int SW = stage_w(WID, N_LOG2);
    localparam int RW = SW + 1;

    logic              en;
    logic [N_LOG2:0]   vld_pipe;
    logic [SW-1:0]     final_sum;
    logic [RW-1:0]     sum_ext, sum_rnd;
    logic [WID-1:0]    mean_d, mean_q;
    logic              out_valid_d, out_valid_q;
    logic              unused_rnd;

    // A single enable freezes the whole pipe whenever the output is held.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;
    assign vld_pipe[0] = in_valid;

    for (genvar k = 1; k <= N_LOG2; k++) begin : g_stage
        localparam int IW = stage_w(WID, k - 1);
        localparam int NI = N >> (k - 1);

        logic [NI*IW-1:0]          st_in;
        logic [(NI/2)*(IW+1)-1:0]  st_out;

        if (k == 1) begin : g_first
            assign st_in = in_data;
        end else begin : g_next
            assign st_in = g_stage[k-1].st_out;
        end

        mean_add_stage #(
            .IN_W   (IW),
            .NUM_IN (NI),
            .SIGNED (SIGNED)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .in_data   (st_in),
            .in_valid  (vld_pipe[k-1]),
            .out_data  (st_out),
            .out_valid (vld_pipe[k])
        );
    end

    assign final_sum = g_stage[N_LOG2].st_out;
    assign sum_ext   = (SIGNED != 0) ? {final_sum[SW-1], final_sum} : {1'b0, final_sum};
    assign sum_rnd   = sum_ext + ((ROUND == ROUND_HALF_UP) ? RW'(round_ofs(N_LOG2)) : RW'(0));

    // Taking bits [N_LOG2 +: WID] equals the shift truncated to WID bits; the
    // arithmetic/logical distinction only touches bits above that window.
    assign unused_rnd = ^{sum_rnd[RW-1], sum_rnd[N_LOG2-1:0]};

    always_comb begin
        mean_d      = mean_q;
        out_valid_d = out_valid_q;
        if (en) begin
            out_valid_d = vld_pipe[N_LOG2];
            mean_d      = sum_rnd[N_LOG2 +: WID];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mean_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            mean_q      <= mean_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_mean  = mean_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mean_tree_avg.sv
// Six configurations of mean_tree_avg driven in parallel and checked against a
// plain-arithmetic mean model through per-instance scoreboards.
module tb_mean_tree_avg;

    logic        clk, rst, in_valid, out_ready;
    logic [15:0] samp [8];
    logic [127:0] pack16;
    logic [15:0] pack8;
    logic [15:0] dmean [6];
    logic        dvld  [6];
    logic        drdy  [6];

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] sb [6][64];
    int          wp [6];
    int          rp [6];
    logic        stall [6];
    logic [15:0] hmean [6];

    assign pack16 = {samp[7], samp[6], samp[5], samp[4], samp[3], samp[2], samp[1], samp[0]};
    assign pack8  = {samp[1][7:0], samp[0][7:0]};

    // d0..d3: WID 16, N_LOG2 3, {SIGNED,ROUND} = 00,01,10,11
    for (genvar g = 0; g < 4; g++) begin : g_w16
        mean_tree_avg #(.WID(16), .N_LOG2(3), .SIGNED(g / 2), .ROUND(g % 2)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_data   (pack16),
            .in_valid  (in_valid),
            .in_ready  (drdy[g]),
            .out_mean  (dmean[g]),
            .out_valid (dvld[g]),
            .out_ready (out_ready)
        );
    end

    // d4, d5: WID 8, N_LOG2 1, unsigned, ROUND 0 / 1
    for (genvar g = 0; g < 2; g++) begin : g_w8
        logic [7:0] m8;
        mean_tree_avg #(.WID(8), .N_LOG2(1), .SIGNED(0), .ROUND(g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_data   (pack8),
            .in_valid  (in_valid),
            .in_ready  (drdy[4+g]),
            .out_mean  (m8),
            .out_valid (dvld[4+g]),
            .out_ready (out_ready)
        );
        assign dmean[4+g] = {8'h00, m8};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Mean of the current sample set as instance d must compute it.
    function automatic logic [15:0] model(input int d);
        int     w  = (d < 4) ? 16 : 8;
        int     nl = (d < 4) ? 3 : 1;
        bit     sg = (d == 2) || (d == 3);
        bit     rn = (d % 2) == 1;
        longint n  = longint'(1) << nl;
        longint mask = (longint'(1) << w) - 1;
        longint sum = 0;
        longint v, q;
        for (int i = 0; i < n; i++) begin
            v = longint'(samp[i]) & mask;
            if (sg && v >= (longint'(1) << (w - 1))) v -= (longint'(1) << w);
            sum += v;
        end
        if (rn) sum += n / 2;
        q = sum / n;
        if ((sum % n) != 0 && sum < 0) q -= 1;
        return 16'(q & mask);
    endfunction

    function automatic logic [15:0] rand_samp();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic set_all(input logic [15:0] v);
        for (int i = 0; i < 8; i++) samp[i] = v;
    endtask

    task automatic randomize_samp();
        for (int i = 0; i < 8; i++) samp[i] = rand_samp();
    endtask

    // Compare process: handshake rule, stall stability and in-order results.
    initial begin
        for (int d = 0; d < 6; d++) begin
            wp[d] = 0; rp[d] = 0; stall[d] = 1'b0; hmean[d] = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 6; d++) begin
                if (rst) begin
                    check($sformatf("rst_in_ready[%0d]", d), drdy[d], 1);
                    check($sformatf("rst_out_valid[%0d]", d), dvld[d], 0);
                    wp[d] = 0; rp[d] = 0; stall[d] = 1'b0;
                end else begin
                    check($sformatf("in_ready_rule[%0d]", d), drdy[d], !dvld[d] || out_ready);
                    if (stall[d]) begin
                        check($sformatf("hold_valid[%0d]", d), dvld[d], 1);
                        check($sformatf("hold_mean[%0d]", d), dmean[d], hmean[d]);
                    end
                    if (dvld[d] && out_ready) begin
                        check($sformatf("result_pending[%0d]", d), wp[d] != rp[d], 1);
                        if (wp[d] != rp[d]) begin
                            check($sformatf("mean[%0d]#%0d", d, rp[d]), dmean[d], sb[d][rp[d] % 64]);
                            rp[d]++;
                        end
                    end
                    if (in_valid && drdy[d]) begin
                        sb[d][wp[d] % 64] = model(d);
                        wp[d]++;
                    end
                    stall[d] = dvld[d] && !out_ready;
                    hmean[d] = dmean[d];
                end
            end
        end
    end

    // One isolated set into an empty pipe: pin model, latency and value.
    task automatic run_set(input string nm, input logic [15:0] e0, e1, e2, e3, e4, e5);
        logic [15:0] ex  [6];
        logic [15:0] got [6];
        int          lat [6];
        ex = '{e0, e1, e2, e3, e4, e5};
        for (int d = 0; d < 6; d++) begin
            check($sformatf("%s_model[%0d]", nm, d), model(d), ex[d]);
            lat[d] = 0;
            got[d] = '0;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            for (int d = 0; d < 6; d++) begin
                if (dvld[d] && lat[d] == 0) begin
                    lat[d] = c;
                    got[d] = dmean[d];
                end
            end
            @(posedge clk); #1;
        end
        for (int d = 0; d < 6; d++) begin
            check($sformatf("%s_latency[%0d]", nm, d), lat[d], (d < 4) ? 4 : 2);
            check($sformatf("%s_value[%0d]", nm, d), got[d], ex[d]);
        end
    endtask

    initial begin
        logic [0:4] pat;
        int         acc0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_all(16'h0000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int d = 0; d < 6; d++) begin
            check($sformatf("reset_valid[%0d]", d), dvld[d], 0);
            check($sformatf("reset_mean[%0d]", d), dmean[d], 0);
            check($sformatf("reset_ready[%0d]", d), drdy[d], 1);
        end

        for (int i = 0; i < 8; i++) samp[i] = 16'(i + 1);
        run_set("seq1to8", 16'd4, 16'd5, 16'd4, 16'd5, 16'd1, 16'd2);

        set_all(16'hFFFF);
        run_set("all_ones", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h00FF, 16'h00FF);

        set_all(16'h0000);
        samp[0] = 16'hFFFD;
        samp[1] = 16'hFFFE;
        run_set("neg5", 16'h3FFF, 16'h3FFF, 16'hFFFF, 16'hFFFF, 16'h00FD, 16'h00FE);

        set_all(16'h8000);
        run_set("all_min", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h0000);

        // Bubble pattern 1,0,0,1,1 must reappear on out_valid after the latency.
        pat = 5'b10011;
        out_ready = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            in_valid = (e <= 5) ? pat[e-1] : 1'b0;
            randomize_samp();
            @(posedge clk); #1;
            if (e >= 4 && e <= 8) check($sformatf("bubble16_e%0d", e), dvld[0], pat[e-4]);
            if (e >= 2 && e <= 6) check($sformatf("bubble8_e%0d", e), dvld[4], pat[e-2]);
        end

        // Random streaming with backpressure.
        acc0 = wp[0];
        for (int cyc = 0; cyc < 300; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            randomize_samp();
            @(posedge clk); #1;
        end
        check("stream_sets_ge20", (wp[0] - acc0) >= 20, 1);

        // Reset with sets in flight: nothing may emerge afterwards.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        repeat (3) begin
            randomize_samp();
            @(posedge clk); #1;
        end
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 6; d++) check($sformatf("post_rst_valid[%0d]", d), dvld[d], 0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 6; d++) check($sformatf("post_rst_quiet[%0d]", d), dvld[d], 0);
        end

        set_all(16'h0000);
        samp[0] = 16'h00FF;
        run_set("ff_and_0", 16'h001F, 16'h0020, 16'h001F, 16'h0020, 16'h007F, 16'h0080);

        // Drain and confirm every accepted set produced exactly one result.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        for (int d = 0; d < 6; d++) check($sformatf("drained[%0d]", d), rp[d], wp[d]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mean_tree_avg.md
Name: mean_tree_avg

Overview:
Pipelined, parametrised arithmetic mean of 2^N_LOG2 parallel samples.
- Generalises the fixed 8-input mean block in four ways: configurable channel count, signed/unsigned operands, selectable rounding, and a valid/ready handshake with full-pipeline stall.
- Sits between parallel sample sources (e.g. a polyphase ADC front end or a multi-lane sensor capture) and downstream filtering that may apply backpressure.

Parameters:
WID, 16, sample width in bits (2..32)
N_LOG2, 3, log2 of input count; N = 2^N_LOG2 inputs (1..8)
SIGNED, 0, 1 = two's-complement samples and result; 0 = unsigned
ROUND, 0, 0 = truncate (floor); 1 = round half up (toward +inf)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_data  in  WID*N  packed samples; sample i = in_data[i*WID +: WID]
in_valid  in  1  in_data is valid this cycle
in_ready  out  1  block accepts data this cycle
out_mean  out  WID  mean of one accepted sample set
out_valid  out  1  out_mean is valid
out_ready  in  1  downstream accepts out_mean

Behaviour:
- Reset: all tree registers, per-stage valid bits, out_mean and out_valid clear to 0 asynchronously. in_ready is combinational and equals 1 while the block is in reset.
- Global enable: en = !out_valid || out_ready. in_ready = en.
- When en = 1, every stage advances one step. When en = 0, every stage register and valid bit holds.
- Transfer rules:
  - A set is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
- Pipeline has N_LOG2 adder stages plus one output stage, giving latency N_LOG2+1 enabled cycles from acceptance to out_valid.
  - Default configuration: latency 4.
- Tree structure and widths:
  - Stage k (1..N_LOG2) holds N/2^k partial sums, each WID+k bits wide.
  - Partial sum j of stage k = element 2j + element 2j+1 of stage k-1. Stage 0 is the inputs.
  - Operands are sign-extended when SIGNED = 1, zero-extended otherwise.
  - No overflow is possible at any stage.
- Valid tracking: a valid bit travels alongside each stage. Bubbles (in_valid = 0 while en = 1) propagate as invalid slots. Data in invalid slots is don't-care but must not affect any valid result.
- Output stage, with S = final sum of WID+N_LOG2 bits:
  - ROUND = 0: out_mean = S >>> N_LOG2 (arithmetic shift if SIGNED, logical otherwise), taking the low WID bits.
  - ROUND = 1: out_mean = (S + 2^(N_LOG2-1)) >>> N_LOG2, computed at WID+N_LOG2+1 bits, taking the low WID bits.
  - The result is always within the input range, so no saturation is needed.
- Back-to-back operation: with out_ready held at 1, one set is accepted and one result is produced every cycle (full throughput).
- Stall: out_ready = 0 while out_valid = 1:
  - in_ready drops in the same cycle.
  - out_mean and out_valid stay stable until the handshake completes.
  - No data is lost or duplicated.
- Simultaneous events: out_ready rising while in_valid = 1 means the input is accepted and the output consumed in the same edge.
- Reset mid-operation: all in-flight sets are discarded. out_valid = 0 on the first cycle after reset deasserts.

Decomposition:
- Package mean_pkg holds:
  - ROUND_TRUNC = 0 and ROUND_HALF_UP = 1 constants.
  - A function for stage width (WID+k).
  - A function for the rounding offset (2^(N_LOG2-1)).
- Sub-module mean_add_stage: one tree level, with parameters IN_W, NUM_IN and SIGNED.
  - Registered pairwise adds with enable and a valid bit.
  - Instantiated N_LOG2 times under a generate loop.
- The output/rounding stage is inline in mean_tree_avg.

Test Plan:
1. Default config, unsigned, truncate. in_data = 1, 2, …, 8 (sum 36), out_ready = 1 -> out_mean = 4 with out_valid exactly 4 cycles after acceptance. Same inputs with ROUND = 1 -> out_mean = 5 (36/8 = 4.5 rounds up).
2. Unsigned extremes, all 8 inputs = 16'hFFFF -> out_mean = 16'hFFFF for both ROUND modes, with no wrap.
3. SIGNED = 1. Inputs -3, -2, 0, 0, 0, 0, 0, 0 (sum -5):
   - ROUND = 0 -> out_mean = -1 (16'hFFFF).
   - ROUND = 1 -> out_mean = -1 ((-5+4)>>>3).
   All inputs 16'h8000 -> 16'h8000.
4. Streaming with backpressure: 20 random sets back to back, out_ready toggling pseudo-randomly -> the scoreboard matches all 20 results in order; out_mean is stable while out_valid && !out_ready; in_ready == (!out_valid || out_ready) every cycle.
5. Bubbles: in_valid pattern 1,0,0,1,1 -> out_valid pattern 1,0,0,1,1 after the latency, with correct values.
6. Config N_LOG2 = 1, WID = 8 (latency 2), inputs 255 and 0 -> 127 truncated, 128 rounded. Assert rst mid-stream with 3 sets in flight -> none emerge, and out_valid = 0 after release.
